// File: rtl/seg_arb_pkg.sv
// Shared types, constants and helpers for the 7-segment display arbiter.
package seg_arb_pkg;

   localparam int NUM_REQ = 3;
   localparam int IDX_W   = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

   typedef logic [IDX_W-1:0] req_idx_t;

   // Requester whose successor gets first priority after reset (requester 0).
   localparam req_idx_t LAST_RESET = 2'd2;

   // Decimal-point pattern lit for each granted source.
   localparam logic [3:0] DOT_REQ0 = 4'b0001;
   localparam logic [3:0] DOT_REQ1 = 4'b0010;
   localparam logic [3:0] DOT_REQ2 = 4'b0100;
   localparam logic [3:0] DOT_NONE = 4'b0000;

   function automatic logic [3:0] dot_code(input req_idx_t idx);
      case (idx)
         2'd0:    dot_code = DOT_REQ0;
         2'd1:    dot_code = DOT_REQ1;
         2'd2:    dot_code = DOT_REQ2;
         default: dot_code = DOT_NONE;
      endcase
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
      case (idx)
         2'd0:    onehot = 3'b001;
         2'd1:    onehot = 3'b010;
         2'd2:    onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
   endfunction

   // Successor index modulo NUM_REQ.
   function automatic req_idx_t next_idx(input req_idx_t idx);
      if (idx == 2'd2) begin
         next_idx = 2'd0;
      end else begin
         next_idx = idx + 2'd1;
      end
   endfunction

   // Round-robin pick: search starts just after 'last'; 'last' itself has lowest priority.
   function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] req, input req_idx_t last);
      req_idx_t c1;
      req_idx_t c2;
      c1 = next_idx(last);
      c2 = next_idx(c1);
      if (req[c1]) begin
         rr_pick = c1;
      end else if (req[c2]) begin
         rr_pick = c2;
      end else begin
         rr_pick = last;
      end
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Minimum-grant-length counter: clears on a new grant, counts HOLD cycles, saturates.
module hold_timer #(
   parameter int HOLD_TICKS = 100000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic sat_o
);

   localparam int CNT_W = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_TICKS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins over enable; stop at CNT_MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = CNT_W'(0);
      end else if (enable_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= CNT_W'(0);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit display between three value sources.
module seg_display_arbiter
   import seg_arb_pkg::*;
#(
   parameter int HOLD_TICKS  = 100000000,
   parameter int VALUE_WIDTH = 16
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NUM_REQ-1:0]     REQ_IN,
   input  logic [VALUE_WIDTH-1:0] VALUE0_IN,
   input  logic [VALUE_WIDTH-1:0] VALUE1_IN,
   input  logic [VALUE_WIDTH-1:0] VALUE2_IN,
   output logic [NUM_REQ-1:0]     GNT_OUT,
   output logic [VALUE_WIDTH-1:0] VALUE_OUT,
   output logic [3:0]             DOT_OUT,
   output logic                   BUSY_OUT
);

   arb_state_e             state_q, state_d;
   req_idx_t               owner_q, owner_d;   // current owner / last granted
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [3:0]             dot_q, dot_d;
   logic                   busy_q, busy_d;
   logic [VALUE_WIDTH-1:0] value_q, value_d;

   logic                   tmr_clear_s;
   logic                   tmr_enable_s;
   logic                   tmr_sat_s;
   logic [NUM_REQ-1:0]     others_s;
   logic [VALUE_WIDTH-1:0] value_sel_s;

   hold_timer #(
      .HOLD_TICKS (HOLD_TICKS)
   ) u_hold_timer (
      .clk_i    (CLK),
      .rst_i    (RESET),
      .clear_i  (tmr_clear_s),
      .enable_i (tmr_enable_s),
      .sat_o    (tmr_sat_s)
   );

   // Next-state and grant decision.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      tmr_clear_s  = 1'b0;
      tmr_enable_s = 1'b0;
      others_s     = REQ_IN & ~gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|REQ_IN) begin
               state_d     = ST_HOLD;
               owner_d     = rr_pick(REQ_IN, owner_q);
               tmr_clear_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!REQ_IN[owner_q]) begin
               // Owner released: plain re-arbitration among whoever is left.
               if (|REQ_IN) begin
                  owner_d     = rr_pick(REQ_IN, owner_q);
                  tmr_clear_s = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (tmr_sat_s) begin
               // Minimum time served: yield to any competitor, else keep holding.
               if (|others_s) begin
                  owner_d     = rr_pick(others_s, owner_q);
                  tmr_clear_s = 1'b1;
               end else begin
                  tmr_enable_s = 1'b1;
               end
            end else begin
               tmr_enable_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Source value for whoever owns the display after this edge.
   always_comb begin
      value_sel_s = value_q;
      case (owner_d)
         2'd0:    value_sel_s = VALUE0_IN;
         2'd1:    value_sel_s = VALUE1_IN;
         2'd2:    value_sel_s = VALUE2_IN;
         default: value_sel_s = value_q;
      endcase
   end

   // Output next values; idle clears the indicators but keeps the last value shown.
   always_comb begin
      gnt_d   = 3'b000;
      dot_d   = DOT_NONE;
      busy_d  = 1'b0;
      value_d = value_q;
      if (state_d == ST_HOLD) begin
         gnt_d   = onehot(owner_d);
         dot_d   = dot_code(owner_d);
         busy_d  = 1'b1;
         value_d = value_sel_s;
      end else begin
         value_d = value_q;
      end
   end

   // State and registered outputs with asynchronous reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         owner_q <= LAST_RESET;
         gnt_q   <= 3'b000;
         dot_q   <= DOT_NONE;
         busy_q  <= 1'b0;
         value_q <= {VALUE_WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         dot_q   <= dot_d;
         busy_q  <= busy_d;
         value_q <= value_d;
      end
   end

   assign GNT_OUT   = gnt_q;
   assign DOT_OUT   = dot_q;
   assign BUSY_OUT  = busy_q;
   assign VALUE_OUT = value_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, randomized model comparison.
module tb_seg_display_arbiter;

   localparam int H = 4;

   logic        CLK;
   logic        RESET;
   logic [2:0]  REQ_IN;
   logic [15:0] VALUE0_IN, VALUE1_IN, VALUE2_IN;
   logic [2:0]  GNT_OUT;
   logic [15:0] VALUE_OUT;
   logic [3:0]  DOT_OUT;
   logic        BUSY_OUT;

   int checks = 0;
   int errors = 0;

   seg_display_arbiter #(
      .HOLD_TICKS  (H),
      .VALUE_WIDTH (16)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .REQ_IN    (REQ_IN),
      .VALUE0_IN (VALUE0_IN),
      .VALUE1_IN (VALUE1_IN),
      .VALUE2_IN (VALUE2_IN),
      .GNT_OUT   (GNT_OUT),
      .VALUE_OUT (VALUE_OUT),
      .DOT_OUT   (DOT_OUT),
      .BUSY_OUT  (BUSY_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0]  req;
      logic [15:0] v0, v1, v2;
      logic [2:0]  gnt;
      logic [3:0]  dot;
      logic        busy;
      logic [15:0] val;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [2:0] req, input logic [15:0] v0, input logic [15:0] v1,
                      input logic [15:0] v2, input logic [2:0] gnt, input logic [3:0] dot,
                      input logic busy, input logic [15:0] val, input int n);
      vec_t r;
      r.req = req; r.v0 = v0; r.v1 = v1; r.v2 = v2;
      r.gnt = gnt; r.dot = dot; r.busy = busy; r.val = val;
      for (int i = 0; i < n; i++) tbl.push_back(r);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] g, input logic [3:0] d,
                           input logic b, input logic [15:0] v);
      chk({tag, "_gnt"}, 32'(GNT_OUT), 32'(g));
      chk({tag, "_dot"}, 32'(DOT_OUT), 32'(d));
      chk({tag, "_busy"}, 32'(BUSY_OUT), 32'(b));
      chk({tag, "_val"}, 32'(VALUE_OUT), 32'(v));
      chk({tag, "_onehot"}, 32'($countones(GNT_OUT) <= 1), 32'(1));
   endtask

   // Reference model: owner index (-1 idle), cycles held since grant, last granted, shown value.
   int m_owner, m_held, m_last, m_val;

   function automatic int rr(input int mask, input int last);
      for (int k = 1; k <= 3; k++) begin
         int idx;
         idx = (last + k) % 3;
         if (((mask >> idx) & 1) == 1) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_last = 2; m_val = 0;
   endtask

   task automatic model_step(input int req, input int v0, input int v1, input int v2);
      int vals[3];
      int grant;
      vals[0] = v0; vals[1] = v1; vals[2] = v2;
      grant = -1;
      if (m_owner < 0) begin
         if (req != 0) grant = rr(req, m_last);
      end else if (((req >> m_owner) & 1) == 0) begin
         if (req != 0) grant = rr(req, m_owner);
         else m_owner = -1;
      end else if (m_held >= H - 1) begin
         int others;
         others = req & ~(1 << m_owner);
         if (others != 0) grant = rr(others, m_owner);
         else m_val = vals[m_owner];
      end else begin
         m_held++;
         m_val = vals[m_owner];
      end
      if (grant >= 0) begin
         m_owner = grant; m_last = grant; m_held = 0; m_val = vals[grant];
      end
   endtask

   initial begin
      RESET = 1'b0; REQ_IN = 3'b000;
      VALUE0_IN = 16'h0000; VALUE1_IN = 16'h0000; VALUE2_IN = 16'h0000;
      #1 RESET = 1'b1;
      #2;
      chk_outs("reset", 3'b000, 4'b0000, 1'b0, 16'h0000);
      step(); step();
      RESET = 1'b0;

      // Directed vector table, applied cycle by cycle from reset.
      add(3'b001, 16'h1234, 16'h0000, 16'h0000, 3'b001, 4'b0001, 1'b1, 16'h1234, 1);
      add(3'b000, 16'h1234, 16'h0000, 16'h0000, 3'b000, 4'b0000, 1'b0, 16'h1234, 1);
      add(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b010, 4'b0010, 1'b1, 16'h2222, 4);
      add(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b100, 4'b0100, 1'b1, 16'h3333, 4);
      add(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 4'b0001, 1'b1, 16'h1111, 4);
      add(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b010, 4'b0010, 1'b1, 16'h2222, 1);
      add(3'b010, 16'h1111, 16'h2222, 16'h3333, 3'b010, 4'b0010, 1'b1, 16'h2222, 10);
      add(3'b110, 16'h1111, 16'h2222, 16'h3333, 3'b100, 4'b0100, 1'b1, 16'h3333, 1);
      add(3'b000, 16'h1111, 16'h2222, 16'h3333, 3'b000, 4'b0000, 1'b0, 16'h3333, 1);
      add(3'b001, 16'h1234, 16'h2222, 16'h3333, 3'b001, 4'b0001, 1'b1, 16'h1234, 1);
      add(3'b001, 16'hBEEF, 16'h2222, 16'h3333, 3'b001, 4'b0001, 1'b1, 16'hBEEF, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         REQ_IN = tbl[i].req;
         VALUE0_IN = tbl[i].v0; VALUE1_IN = tbl[i].v1; VALUE2_IN = tbl[i].v2;
         step();
         chk_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].dot, tbl[i].busy, tbl[i].val);
      end

      // Reset pulsed mid-grant: outputs clear without a clock edge, priority restarts.
      REQ_IN = 3'b001;
      step();
      #1 RESET = 1'b1;
      #1;
      chk_outs("midreset", 3'b000, 4'b0000, 1'b0, 16'h0000);
      #1 RESET = 1'b0;
      REQ_IN = 3'b110;
      step();
      chk_outs("after_reset", 3'b010, 4'b0010, 1'b1, 16'h2222);

      // Randomized traffic compared against the reference model.
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      REQ_IN = 3'b000;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5, 0) == 0) REQ_IN = 3'($urandom_range(7, 0));
         if ($urandom_range(2, 0) == 0) VALUE0_IN = 16'($urandom);
         if ($urandom_range(2, 0) == 0) VALUE1_IN = 16'($urandom);
         if ($urandom_range(2, 0) == 0) VALUE2_IN = 16'($urandom);
         model_step(int'(REQ_IN), int'(VALUE0_IN), int'(VALUE1_IN), int'(VALUE2_IN));
         step();
         chk_outs($sformatf("rand%0d", c),
                  (m_owner < 0) ? 3'b000 : 3'(1 << m_owner),
                  (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner),
                  (m_owner >= 0),
                  16'(m_val));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
